// File: rtl/rca_16_bit.sv
// rtl/rca_16_bit.sv - 16-bit registered ripple-carry adder built from full-adder slices

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module rca_16_bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);

    // c[i] is the carry into slice i; c[16] leaves the top slice
    logic [16:0] c;
    logic [15:0] s;

    assign c[0] = carry_in;

    for (genvar i = 0; i < 16; i++) begin : g_slice
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Capture the combinational result each edge; reset wins and discards the operation
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= 16'h0000;
            carry_out <= 1'b0;
        end else begin
            sum       <= s;
            carry_out <= c[16];
        end
    end

endmodule

// File: tb/tb_rca_16_bit.sv
// tb/tb_rca_16_bit.sv - scoreboard bench for rca_16_bit

module tb_rca_16_bit;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic        carry_in;
    logic [15:0] sum;
    logic        carry_out;

    logic        issued;
    exp_t        exp_q[$];
    int          n_applied;
    int          n_miscompare;

    rca_16_bit dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector for the next rising edge and queue its expected result
    task automatic apply(input logic r, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] es, input logic eco);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        x        = a;
        y        = b;
        carry_in = ci;
        issued   = 1'b1;
        e.s      = es;
        e.co     = eco;
        exp_q.push_back(e);
    endtask

    // Monitor: a vector issued for an edge is checked on the following negedge
    initial begin
        logic due;
        exp_t e;
        forever begin
            @(posedge clk);
            due = issued;
            @(negedge clk);
            if (due) begin
                n_applied++;
                if (exp_q.size() == 0) begin
                    n_miscompare++;
                    $display("FAIL scoreboard_empty: got sum=%0d carry_out=%0b, required a queued expectation",
                             sum, carry_out);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e.s || carry_out !== e.co) begin
                        n_miscompare++;
                        $display("FAIL add_result #%0d: got sum=%0d carry_out=%0b, required sum=%0d carry_out=%0b",
                                 n_applied, sum, carry_out, e.s, e.co);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] ref_sum;

        n_applied    = 0;
        n_miscompare = 0;
        issued       = 1'b0;
        rst          = 1'b1;
        x            = 16'd0;
        y            = 16'd0;
        carry_in     = 1'b0;

        // Reset for two edges with live operands
        apply(1'b1, 16'd1234, 16'd4321, 1'b1, 16'd0, 1'b0);
        apply(1'b1, 16'd1234, 16'd4321, 1'b1, 16'd0, 1'b0);

        // Basic adds, back to back
        apply(1'b0, 16'd1060,  16'd11000, 1'b0, 16'd12060, 1'b0);
        apply(1'b0, 16'd12500, 16'd3100,  1'b1, 16'd15601, 1'b0);
        apply(1'b0, 16'd30143, 16'd2200,  1'b0, 16'd32343, 1'b0);
        apply(1'b0, 16'd1140,  16'd21000, 1'b1, 16'd22141, 1'b0);

        // Wrap-around
        apply(1'b0, 16'd65505, 16'd31,    1'b0, 16'd0, 1'b1);
        apply(1'b0, 16'd32005, 16'd33533, 1'b0, 16'd2, 1'b1);

        // Full-length carry propagation
        apply(1'b0, 16'd65535, 16'd65535, 1'b1, 16'd65535, 1'b1);
        apply(1'b0, 16'd65535, 16'd0,     1'b1, 16'd0,     1'b1);
        apply(1'b0, 16'd0,     16'd0,     1'b0, 16'd0,     1'b0);

        // Mid-stream reset discards its operation, next vector resumes
        apply(1'b0, 16'd1060,  16'd11000, 1'b0, 16'd12060, 1'b0);
        apply(1'b1, 16'd12500, 16'd3100,  1'b1, 16'd0,     1'b0);
        apply(1'b0, 16'd30143, 16'd2200,  1'b0, 16'd32343, 1'b0);
        apply(1'b0, 16'd1140,  16'd21000, 1'b1, 16'd22141, 1'b0);

        // Random vectors against a 17-bit reference sum
        for (int i = 0; i < 10000; i++) begin
            ra      = 16'($urandom);
            rb      = 16'($urandom);
            rc      = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            apply(1'b0, ra, rb, rc, ref_sum[15:0], ref_sum[16]);
        end

        @(posedge clk);
        #1;
        issued = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        if (exp_q.size() != 0) begin
            n_miscompare++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule

// File: doc/rca_16_bit.md
RCA_16_BIT -- requirements
Module: rca_16_bit

Interface
REQ-001 No parameters; operand width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 x  input  16  addend A, unsigned.
REQ-005 y  input  16  addend B, unsigned.
REQ-006 carry_in  input  1  carry into bit 0.
REQ-007 sum  output  16  registered sum bits [15:0].
REQ-008 carry_out  output  1  registered carry out of bit 15.

Function
REQ-009 The adder datapath SHALL be a ripple-carry chain of 16 one-bit full-adder slices.
- Slice i computes s[i] = x[i] ^ y[i] ^ c[i] and c[i+1] = majority(x[i], y[i], c[i]).
- c[0] = carry_in; c[16] = raw carry out.
REQ-010 Each full-adder slice SHALL be a separate reusable submodule instantiated 16 times.
- No behavioural "+" operator on the full width.
REQ-011 The combinational result SHALL equal the 17-bit unsigned value x + y + carry_in, with {c[16], s[15:0]} forming that value.
REQ-012 On each rising clk edge with rst low, the block SHALL capture s into sum and c[16] into carry_out.
REQ-013 Latency SHALL be exactly one clock.
- Inputs present at edge N appear on the outputs after edge N.
- One new operation is accepted every cycle.
- No handshake and no stall.
REQ-014 Outputs SHALL change only on rising clk edges; they hold between edges regardless of input activity.
REQ-015 Wrap-around: when x + y + carry_in >= 65536, sum SHALL be the low 16 bits and carry_out SHALL be 1.
REQ-016 No signed-overflow flag is produced; interpretation is unsigned only.
REQ-017 The worst-case carry path (x=y=16'hFFFF, carry_in=1, propagating through all 16 slices) SHALL meet timing within one clk period at the target frequency.

Reset
REQ-018 When rst is high at a rising clk edge, sum SHALL be 16'h0000 and carry_out SHALL be 0 after that edge.
- This applies regardless of x, y and carry_in.
REQ-019 Reset SHALL take priority over capture; an operation sampled in a reset cycle is discarded.
REQ-020 In the first cycle with rst low, inputs SHALL be captured normally, and the result is visible after that edge.
REQ-021 Output values before the first reset edge are undefined; the bench SHALL apply rst for at least one edge before checking outputs.

Verification
REQ-022 Reset: rst=1 for 2 edges with x=1234, y=4321, carry_in=1 -> sum=0, carry_out=0.
REQ-023 Basic adds, one cycle apart, each checked one cycle after apply:
- 1060 + 11000 + 0 -> sum=12060, carry_out=0.
- 12500 + 3100 + 1 -> sum=15601, carry_out=0.
- 30143 + 2200 + 0 -> sum=32343, carry_out=0.
- 1140 + 21000 + 1 -> sum=22141, carry_out=0.
REQ-024 Wrap-around cases:
- 65505 + 31 + 0 -> sum=0, carry_out=1.
- 32005 + 33533 + 0 -> sum=2, carry_out=1.
REQ-025 Critical path: 65535 + 65535 + 1 -> sum=65535, carry_out=1.
- Also 65535 + 0 + 1 -> sum=0, carry_out=1 (full-length propagate).
REQ-026 Back-to-back and mid-stream reset:
- Apply the REQ-023 vectors on consecutive cycles and check each result at exactly one-cycle latency.
- Assert rst for one edge mid-stream -> that cycle's outputs are 0/0, and the next vector resumes correctly.
REQ-027 Randomized: at least 10,000 random (x, y, carry_in) vectors compared against a 17-bit reference sum with one-cycle delay, with zero mismatches.
